gbsha_ttfir_top: RTL and testbench

- Tiny-Tapeout-style 8-in/8-out wrapper around a small signed FIR filter, y[n] = sum h[k]*x[n-k].
- Clock, reset and sample input are all packed into io_in; the filtered output drives io_out.
- Top-level user block; it has no other interfaces.

---
 rtl/gbsha_ttfir_pkg.sv | 40 ++++
 rtl/gbsha_ttfir_core.sv | 46 ++++
 rtl/gbsha_ttfir_top.sv | 57 +++++
 tb/tb_gbsha_ttfir_top.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/gbsha_ttfir_pkg.sv
// Shared defaults, coefficient array type and arithmetic helpers
// for the Tiny-Tapeout FIR wrapper.
package gbsha_ttfir_pkg;

    localparam int N_TAPS_DEF  = 3;
    localparam int BW_IN_DEF   = 6;
    localparam int BW_OUT_DEF  = 8;
    localparam int BW_COEF_DEF = 4;
    localparam int MAX_TAPS    = 8;

    // Entries beyond N_TAPS are ignored by the core.
    typedef int coef_arr_t [MAX_TAPS];

    localparam coef_arr_t COEFS_DEF = '{1, 2, 1, 0, 0, 0, 0, 0};

    function automatic int acc_width(
        input int bw_in,
        input int bw_coef,
        input int n_taps
    );
        return bw_in + bw_coef + $clog2(n_taps);
    endfunction

    function automatic logic signed [31:0] saturate(
        input logic signed [31:0] v,
        input int                 bw
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (bw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (bw - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/gbsha_ttfir_core.sv
// Delay line, multiply-accumulate and output saturation of the
// signed FIR filter.
module gbsha_ttfir_core
    import gbsha_ttfir_pkg::*;
#(
    parameter int        N_TAPS  = N_TAPS_DEF,
    parameter int        BW_in   = BW_IN_DEF,
    parameter int        BW_out  = BW_OUT_DEF,
    parameter int        BW_coef = BW_COEF_DEF,
    parameter coef_arr_t COEFS   = COEFS_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [BW_in-1:0]  x_in,
    output logic signed [BW_out-1:0] y_out
);

    localparam int AW = acc_width(BW_in, BW_coef, N_TAPS);

    logic signed [BW_in-1:0] d [N_TAPS];
    logic signed [AW-1:0]    acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_TAPS; k++)
                d[k] <= '0;
        end else begin
            d[0] <= x_in;
            for (int k = 1; k < N_TAPS; k++)
                d[k] <= d[k-1];
        end
    end

    // Both operands are widened to the full accumulator before the
    // multiply so no partial product or running sum can wrap.
    always_comb begin
        acc = '0;
        for (int k = 0; k < N_TAPS; k++)
            acc = acc
                + AW'($signed(COEFS[k][BW_coef-1:0]))
                * AW'(d[k]);
    end

    assign y_out = BW_out'(saturate(32'(acc), BW_out));

endmodule

// File: rtl/gbsha_ttfir_top.sv
// 8-in/8-out pin wrapper: unpacks clock, reset and sample from io_in,
// synchronises reset release and drives the filter result on io_out.
module gbsha_ttfir_top
    import gbsha_ttfir_pkg::*;
#(
    parameter int        N_TAPS  = N_TAPS_DEF,
    parameter int        BW_in   = BW_IN_DEF,
    parameter int        BW_out  = BW_OUT_DEF,
    parameter int        BW_coef = BW_COEF_DEF,
    parameter coef_arr_t COEFS   = COEFS_DEF
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic                     clk;
    logic                     rst_async_n;
    logic                     rst_n;
    logic [1:0]               rst_sync;
    logic signed [BW_in-1:0]  x_in;
    logic signed [BW_out-1:0] y_out;
    logic                     unused_io;

    assign clk         = io_in[0];
    assign rst_async_n = io_in[1];
    assign x_in        = io_in[BW_in+1:2];
    assign unused_io   = ^io_in;

    // Assertion is immediate; release only after two clean edges.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n)
            rst_sync <= '0;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    gbsha_ttfir_core #(
        .N_TAPS  (N_TAPS),
        .BW_in   (BW_in),
        .BW_out  (BW_out),
        .BW_coef (BW_coef),
        .COEFS   (COEFS)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .x_in  (x_in),
        .y_out (y_out)
    );

    always_comb begin
        io_out             = '0;
        io_out[BW_out-1:0] = y_out;
    end

endmodule

// File: tb/tb_gbsha_ttfir_top.sv
// Directed vector bench for gbsha_ttfir_top: default taps, saturating
// {7,7,7} taps and a 6-bit output build share one pin stimulus.
module tb_gbsha_ttfir_top;
    import gbsha_ttfir_pkg::*;

    localparam coef_arr_t SAT_C = '{7, 7, 7, 0, 0, 0, 0, 0};

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic signed [5:0] x   = '0;
    logic [7:0]        io_in;
    logic [7:0]        out_def;
    logic [7:0]        out_sat;
    logic [7:0]        out_n6;

    int n_tests = 0;
    int n_fail  = 0;

    assign io_in = {x, rst, clk};

    always #5 clk = ~clk;

    gbsha_ttfir_top u_def (
        .io_in  (io_in),
        .io_out (out_def)
    );

    gbsha_ttfir_top #(
        .COEFS (SAT_C)
    ) u_sat (
        .io_in  (io_in),
        .io_out (out_sat)
    );

    gbsha_ttfir_top #(
        .BW_out (6)
    ) u_n6 (
        .io_in  (io_in),
        .io_out (out_n6)
    );

    typedef struct {
        bit                rst_before;
        logic signed [5:0] x;
        logic signed [7:0] e_def;
        logic signed [7:0] e_sat;
        logic signed [5:0] e_n6;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit r, input int xv, input int ed,
                                input int es, input int e6);
        vec_t v;
        v.rst_before = r;
        v.x          = 6'(xv);
        v.e_def      = 8'(ed);
        v.e_sat      = 8'(es);
        v.e_n6       = 6'(e6);
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%02h) expected %0d (0x%02h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic chk_all(input string name, input logic signed [7:0] ed,
                           input logic signed [7:0] es,
                           input logic signed [5:0] e6);
        chk({name, "/def"}, out_def, ed);
        chk({name, "/sat"}, out_sat, es);
        chk({name, "/n6"},  out_n6,  {2'b00, e6});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset with a live sample, then release and confirm the two
    // synchroniser edges capture nothing.
    task automatic do_reset();
        rst = 1'b0;
        x   = 6'sd31;
        repeat (3) begin
            tick();
            chk_all("reset_hold", 8'sd0, 8'sd0, 6'sd0);
        end
        rst = 1'b1;
        repeat (2) begin
            tick();
            chk_all("reset_release", 8'sd0, 8'sd0, 6'sd0);
        end
    endtask

    initial begin
        // impulse
        tbl.push_back(mk(1, 1, 1, 7, 1));
        tbl.push_back(mk(0, 0, 2, 7, 2));
        tbl.push_back(mk(0, 0, 1, 7, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0));
        // positive step
        tbl.push_back(mk(0, 31, 31, 127, 31));
        tbl.push_back(mk(0, 31, 93, 127, 31));
        tbl.push_back(mk(0, 31, 124, 127, 31));
        tbl.push_back(mk(0, 31, 124, 127, 31));
        // negative step after mid-stream reset
        tbl.push_back(mk(1, -32, -32, -128, -32));
        tbl.push_back(mk(0, -32, -96, -128, -32));
        tbl.push_back(mk(0, -32, -128, -128, -32));
        tbl.push_back(mk(0, -32, -128, -128, -32));
        // alternating +/-10
        tbl.push_back(mk(1, 10, 10, 70, 10));
        tbl.push_back(mk(0, -10, 10, 0, 10));
        tbl.push_back(mk(0, 10, 0, 70, 0));
        tbl.push_back(mk(0, -10, 0, -70, 0));
        tbl.push_back(mk(0, 10, 0, 70, 0));

        #1;
        chk_all("reset_state", 8'sd0, 8'sd0, 6'sd0);

        foreach (tbl[i]) begin
            if (tbl[i].rst_before) begin
                // asynchronous assert: outputs clear before any edge
                rst = 1'b0;
                #2;
                chk_all("async_reset", 8'sd0, 8'sd0, 6'sd0);
                do_reset();
            end
            // mid-cycle glitch on the sample must not be captured
            x = ~tbl[i].x;
            #2;
            x = tbl[i].x;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_def, tbl[i].e_sat,
                    tbl[i].e_n6);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
